// File: rtl/opreg_writeback_if.sv
// Bus bundle for the operand write-back bank: result handshake, host byte
// load path and the operand/status outputs.
interface opreg_writeback_if #(
  parameter int WIDTH = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_dest;
  logic             host_start;
  logic             host_sel;
  logic             host_byte_valid;
  logic [7:0]       host_byte;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic             busy;
  logic             wb_done;

  modport master (
    output res_valid, res_data, res_dest,
    output host_start, host_sel, host_byte_valid, host_byte,
    input  res_ready, reg_a, reg_b, busy, wb_done
  );

  modport slave (
    input  res_valid, res_data, res_dest,
    input  host_start, host_sel, host_byte_valid, host_byte,
    output res_ready, reg_a, reg_b, busy, wb_done
  );
endinterface

// File: rtl/opreg_writeback.sv
// Operand write-back bank: holds operands A and B, written either by multiplier
// results (valid/ready) or by a byte-serial host load, arbitrated by a small FSM.
module opreg_writeback #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  opreg_writeback_if.slave  bus
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(NBYTES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOST = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-9:0] r_stage;
  logic [CW-1:0]    r_cnt;
  logic             r_sel;

  logic             w_wr_a;
  logic             w_wr_b;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_host_go;
  logic             w_byte_acc;
  logic [WIDTH-1:0] w_shifted;

  // Staging holds only the bytes already received; the last byte joins combinationally.
  assign w_shifted = {r_stage, bus.host_byte};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and write-enable decode
  always_comb begin
    w_next     = r_state;
    w_wr_a     = 1'b0;
    w_wr_b     = 1'b0;
    w_wr_data  = bus.res_data;
    w_host_go  = 1'b0;
    w_byte_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        // res_ready is high throughout IDLE, so res_valid alone is the handshake.
        if (bus.res_valid) begin
          w_next = S_DONE;
          case (bus.res_dest)
            2'b00:   w_wr_a = 1'b1;
            2'b01:   w_wr_b = 1'b1;
            2'b10: begin
              w_wr_a = 1'b1;
              w_wr_b = 1'b1;
            end
            default: w_wr_a = 1'b0;
          endcase
        end else if (bus.host_start) begin
          w_host_go = 1'b1;
          w_next    = S_HOST;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_HOST: begin
        if (bus.host_byte_valid) begin
          w_byte_acc = 1'b1;
          if (r_cnt == CW'(NBYTES - 1)) begin
            w_next    = S_DONE;
            w_wr_data = w_shifted;
            if (r_sel) begin
              w_wr_b = 1'b1;
            end else begin
              w_wr_a = 1'b1;
            end
          end else begin
            w_next = S_HOST;
          end
        end else begin
          w_next = S_HOST;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand registers, host staging and byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_stage <= {(WIDTH-8){1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_sel   <= 1'b0;
    end else if (clear) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_stage <= {(WIDTH-8){1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_sel   <= 1'b0;
    end else begin
      if (w_wr_a) begin
        r_a <= w_wr_data;
      end
      if (w_wr_b) begin
        r_b <= w_wr_data;
      end
      if (w_host_go) begin
        r_sel   <= bus.host_sel;
        r_cnt   <= {CW{1'b0}};
        r_stage <= {(WIDTH-8){1'b0}};
      end else if (w_byte_acc) begin
        r_cnt   <= r_cnt + CW'(1);
        r_stage <= w_shifted[WIDTH-9:0];
      end
    end
  end

  assign bus.res_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.wb_done   = (r_state == S_DONE);
  assign bus.reg_a     = r_a;
  assign bus.reg_b     = r_b;

endmodule

// File: tb/tb_opreg_writeback.sv
// Directed bench for opreg_writeback: table of result writes plus hand-written
// host-load, collision, reset and clear sequences.
module tb_opreg_writeback;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  logic clear;
  int   total;
  int   bad;

  opreg_writeback_if #(.WIDTH(WIDTH)) bus ();

  opreg_writeback #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  dest;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.res_valid       = 1'b0;
    bus.res_data        = 16'h0000;
    bus.res_dest        = 2'b00;
    bus.host_start      = 1'b0;
    bus.host_sel        = 1'b0;
    bus.host_byte_valid = 1'b0;
    bus.host_byte       = 8'h00;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear = 1'b0;
    rst_n = 1'b0;
    idle_inputs();

    vecs[0] = '{data: 16'hBEEF, dest: 2'b10, exp_a: 16'hBEEF, exp_b: 16'hBEEF};
    vecs[1] = '{data: 16'h1234, dest: 2'b01, exp_a: 16'hBEEF, exp_b: 16'h1234};
    vecs[2] = '{data: 16'hFFFF, dest: 2'b11, exp_a: 16'hBEEF, exp_b: 16'h1234};
    vecs[3] = '{data: 16'h5A5A, dest: 2'b00, exp_a: 16'h5A5A, exp_b: 16'h1234};

    // Reset
    #12;
    check("rst_ready_low", {31'd0, bus.res_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_a", {16'd0, bus.reg_a}, 32'd0);
    check("rst_b", {16'd0, bus.reg_b}, 32'd0);
    check("rst_ready", {31'd0, bus.res_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.wb_done}, 32'd0);

    // Back-to-back result writes; the next vector is offered during DONE.
    bus.res_valid = 1'b1;
    bus.res_data  = vecs[0].data;
    bus.res_dest  = vecs[0].dest;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("vec_a", {16'd0, bus.reg_a}, {16'd0, vecs[i].exp_a});
      check("vec_b", {16'd0, bus.reg_b}, {16'd0, vecs[i].exp_b});
      check("vec_done", {31'd0, bus.wb_done}, 32'd1);
      check("vec_busy", {31'd0, bus.busy}, 32'd1);
      check("vec_ready", {31'd0, bus.res_ready}, 32'd0);
      if (i < 3) begin
        bus.res_data = vecs[i+1].data;
        bus.res_dest = vecs[i+1].dest;
      end else begin
        bus.res_valid = 1'b0;
      end
      tick();
      check("vec_done_gone", {31'd0, bus.wb_done}, 32'd0);
      check("vec_ready_back", {31'd0, bus.res_ready}, 32'd1);
      check("vec_hold_a", {16'd0, bus.reg_a}, {16'd0, vecs[i].exp_a});
      check("vec_hold_b", {16'd0, bus.reg_b}, {16'd0, vecs[i].exp_b});
    end

    // Host load of A with a gap between bytes
    bus.host_start = 1'b1;
    bus.host_sel   = 1'b0;
    tick();
    bus.host_start = 1'b0;
    check("hl_busy", {31'd0, bus.busy}, 32'd1);
    check("hl_ready", {31'd0, bus.res_ready}, 32'd0);
    bus.host_byte_valid = 1'b1;
    bus.host_byte       = 8'hA5;
    tick();
    check("hl_partial_a", {16'd0, bus.reg_a}, 32'h5A5A);
    check("hl_done_early", {31'd0, bus.wb_done}, 32'd0);
    bus.host_byte_valid = 1'b0;
    bus.host_byte       = 8'hEE;
    tick();
    check("hl_gap_a", {16'd0, bus.reg_a}, 32'h5A5A);
    check("hl_gap_ready", {31'd0, bus.res_ready}, 32'd0);
    bus.host_byte_valid = 1'b1;
    bus.host_byte       = 8'h3C;
    tick();
    bus.host_byte_valid = 1'b0;
    check("hl_full_a", {16'd0, bus.reg_a}, 32'hA53C);
    check("hl_keep_b", {16'd0, bus.reg_b}, 32'h1234);
    check("hl_done", {31'd0, bus.wb_done}, 32'd1);
    tick();
    check("hl_done_once", {31'd0, bus.wb_done}, 32'd0);
    check("hl_idle", {31'd0, bus.busy}, 32'd0);

    // host_start colliding with a result handshake is dropped
    bus.res_valid  = 1'b1;
    bus.res_data   = 16'h0F0F;
    bus.res_dest   = 2'b01;
    bus.host_start = 1'b1;
    bus.host_sel   = 1'b0;
    tick();
    idle_inputs();
    check("col_b", {16'd0, bus.reg_b}, 32'h0F0F);
    check("col_a", {16'd0, bus.reg_a}, 32'hA53C);
    check("col_done", {31'd0, bus.wb_done}, 32'd1);
    tick();
    check("col_idle", {31'd0, bus.busy}, 32'd0);
    check("col_ready", {31'd0, bus.res_ready}, 32'd1);

    // Async reset mid host load, then a clean reload of B
    bus.host_start = 1'b1;
    bus.host_sel   = 1'b1;
    tick();
    bus.host_start      = 1'b0;
    bus.host_byte_valid = 1'b1;
    bus.host_byte       = 8'h11;
    tick();
    bus.host_byte_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("arst_a", {16'd0, bus.reg_a}, 32'd0);
    check("arst_b", {16'd0, bus.reg_b}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_ready", {31'd0, bus.res_ready}, 32'd1);
    rst_n = 1'b1;
    tick();
    bus.host_start = 1'b1;
    bus.host_sel   = 1'b1;
    tick();
    bus.host_start      = 1'b0;
    bus.host_byte_valid = 1'b1;
    bus.host_byte       = 8'hC3;
    tick();
    check("rl_no_leftover", {31'd0, bus.wb_done}, 32'd0);
    check("rl_partial_b", {16'd0, bus.reg_b}, 32'd0);
    bus.host_byte = 8'h7E;
    tick();
    bus.host_byte_valid = 1'b0;
    check("rl_b", {16'd0, bus.reg_b}, 32'hC37E);
    check("rl_a", {16'd0, bus.reg_a}, 32'd0);
    check("rl_done", {31'd0, bus.wb_done}, 32'd1);
    tick();

    // clear wins over a simultaneous handshake
    bus.res_valid = 1'b1;
    bus.res_data  = 16'h9999;
    bus.res_dest  = 2'b10;
    tick();
    bus.res_valid = 1'b0;
    check("pre_clr_a", {16'd0, bus.reg_a}, 32'h9999);
    tick();
    bus.res_valid = 1'b1;
    bus.res_data  = 16'h1111;
    bus.res_dest  = 2'b10;
    clear         = 1'b1;
    tick();
    idle_inputs();
    clear = 1'b0;
    check("clr_a", {16'd0, bus.reg_a}, 32'd0);
    check("clr_b", {16'd0, bus.reg_b}, 32'd0);
    check("clr_done", {31'd0, bus.wb_done}, 32'd0);
    check("clr_busy", {31'd0, bus.busy}, 32'd0);
    check("clr_ready", {31'd0, bus.res_ready}, 32'd1);
    tick();
    check("clr_done_after", {31'd0, bus.wb_done}, 32'd0);
    check("clr_hold_a", {16'd0, bus.reg_a}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
